// File: rtl/journaled_state_cache_pkg.sv
// Shared types for the journaled state cache: opcodes, FSM states and
// the journal entry layout (fields sized for the widest supported config).
package state_cache_pkg;

  typedef enum logic [2:0] {
    OP_READ     = 3'd0,
    OP_WRITE    = 3'd1,
    OP_SNAPSHOT = 3'd2,
    OP_COMMIT   = 3'd3,
    OP_ROLLBACK = 3'd4,
    OP_END_TX   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLLBACK,
    ST_CLEAR
  } state_e;

  localparam int JE_ADDR_W = 16;
  localparam int JE_VAL_W  = 64;

  typedef struct packed {
    logic                 transient;
    logic [JE_ADDR_W-1:0] addr;
    logic [JE_VAL_W-1:0]  val;
  } jrnl_entry_t;

endpackage

// File: rtl/journaled_state_cache_lifo.sv
// Flop-based LIFO with occupancy count; used for both the undo journal
// and the snapshot mark stack.
module state_lifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  top_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_o   = mem_q[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= din_i;
      cnt_q <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/journaled_state_cache.sv
// Two-bank key/value cache with nested snapshots, an undo journal
// replayed one entry per cycle on rollback, and a transient-bank sweep.
module journaled_state_cache
  import state_cache_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int VAL_W        = 32,
  parameter int JRNL_DEPTH   = 32,
  parameter int SNAP_DEPTH   = 8,
  parameter int TRANSIENT_EN = 1,
  localparam int DEPTH = 2 ** ADDR_W,
  localparam int SL_W  = $clog2(SNAP_DEPTH + 1),
  localparam int JC_W  = $clog2(JRNL_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_transient,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [VAL_W-1:0]  cmd_wdata,
  output logic              rsp_valid,
  output logic [VAL_W-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [SL_W-1:0]   snap_level,
  output logic [JC_W-1:0]   jrnl_count,
  output logic              busy
);

  state_e            state_q;
  logic [VAL_W-1:0]  bank_q [2][DEPTH];
  logic [ADDR_W-1:0] clr_idx_q;
  logic [JC_W-1:0]   mark_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [VAL_W-1:0]  rsp_rdata_q;

  logic              accept;
  logic              bsel;
  logic [VAL_W-1:0]  cur_val;
  logic              do_wr;
  logic              do_err;

  jrnl_entry_t       j_din;
  jrnl_entry_t       j_top;
  logic              j_push, j_pop, j_clr;
  logic [JC_W-1:0]   j_cnt;
  logic              j_full, j_empty;

  logic              s_push, s_pop, s_clr;
  logic [JC_W-1:0]   s_top;
  logic [SL_W-1:0]   s_cnt;
  logic              s_full, s_empty;

  logic              unused_je;

  assign accept  = cmd_valid && (state_q == ST_IDLE);
  assign bsel    = (TRANSIENT_EN != 0) && cmd_transient;
  assign cur_val = bank_q[bsel][cmd_addr];

  // Upper entry bits are zero padding for narrower configurations.
  assign unused_je = ^j_top;

  always_comb begin
    do_wr  = 1'b0;
    do_err = 1'b0;
    j_push = 1'b0;
    j_pop  = (state_q == ST_ROLLBACK) && !j_empty;
    j_clr  = 1'b0;
    s_push = 1'b0;
    s_pop  = 1'b0;
    s_clr  = 1'b0;
    j_din  = '0;
    j_din.transient = bsel;
    j_din.addr      = JE_ADDR_W'(cmd_addr);
    j_din.val       = JE_VAL_W'(cur_val);
    if (accept) begin
      case (cmd_op)
        OP_READ: ;
        OP_WRITE: begin
          if (s_empty) begin
            do_wr = 1'b1;
          end else if (j_full) begin
            do_err = 1'b1;
          end else begin
            do_wr  = 1'b1;
            j_push = 1'b1;
          end
        end
        OP_SNAPSHOT: begin
          if (s_full) do_err = 1'b1;
          else s_push = 1'b1;
        end
        OP_COMMIT: begin
          if (s_empty) begin
            do_err = 1'b1;
          end else begin
            s_pop = 1'b1;
            j_clr = (s_cnt == SL_W'(1));
          end
        end
        OP_ROLLBACK: begin
          if (s_empty) do_err = 1'b1;
          else s_pop = 1'b1;
        end
        OP_END_TX: begin
          j_clr = 1'b1;
          s_clr = 1'b1;
        end
        default: do_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_idx_q   <= '0;
      mark_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= do_err;
            if (do_wr) bank_q[bsel][cmd_addr] <= cmd_wdata;
            if (cmd_op == OP_READ) rsp_rdata_q <= cur_val;
            // A mark equal to the journal depth has nothing to undo.
            if (cmd_op == OP_ROLLBACK && !s_empty && s_top != j_cnt) begin
              mark_q      <= s_top;
              state_q     <= ST_ROLLBACK;
              rsp_valid_q <= 1'b0;
            end
            if (cmd_op == OP_END_TX && TRANSIENT_EN != 0) begin
              clr_idx_q   <= '0;
              state_q     <= ST_CLEAR;
              rsp_valid_q <= 1'b0;
            end
          end
        end
        ST_ROLLBACK: begin
          if (!j_empty) begin
            bank_q[j_top.transient][j_top.addr[ADDR_W-1:0]] <=
              j_top.val[VAL_W-1:0];
          end
          if (j_empty || j_cnt == mark_q + JC_W'(1)) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          bank_q[1][clr_idx_q] <= '0;
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  state_lifo #(
    .W     ($bits(jrnl_entry_t)),
    .DEPTH (JRNL_DEPTH)
  ) u_jrnl (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (j_push),
    .pop_i   (j_pop),
    .clr_i   (j_clr),
    .din_i   (j_din),
    .top_o   (j_top),
    .count_o (j_cnt),
    .full_o  (j_full),
    .empty_o (j_empty)
  );

  state_lifo #(
    .W     (JC_W),
    .DEPTH (SNAP_DEPTH)
  ) u_snap (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_push),
    .pop_i   (s_pop),
    .clr_i   (s_clr),
    .din_i   (j_cnt),
    .top_o   (s_top),
    .count_o (s_cnt),
    .full_o  (s_full),
    .empty_o (s_empty)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = !cmd_ready;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign snap_level = s_cnt;
  assign jrnl_count = j_cnt;

endmodule

// File: tb/tb_journaled_state_cache.sv
// Directed bench for journaled_state_cache with hand-computed expectations.
module tb_journaled_state_cache;

  localparam logic [2:0] RD = 3'd0, WR = 3'd1, SN = 3'd2;
  localparam logic [2:0] CM = 3'd3, RB = 3'd4, ET = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic        cmd_transient = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  snap_level;
  logic [5:0]  jrnl_count;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int bcyc;

  always #5 clk = ~clk;

  journaled_state_cache dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_transient (cmd_transient),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .snap_level    (snap_level),
    .jrnl_count    (jrnl_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one command for a single cycle; outputs sampled 1ns after edge.
  task automatic issue(input logic [2:0] op, input logic t,
                       input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_transient = t;
    cmd_addr      = a;
    cmd_wdata     = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_chk(input string tag, input logic t,
                          input logic [3:0] a, input logic [31:0] exp);
    issue(RD, t, a, 32'h0);
    check({tag, "_vld"}, {63'h0, rsp_valid}, 64'h1);
    check(tag, {32'h0, rsp_rdata}, {32'h0, exp});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'h0, cmd_ready}, 64'h1);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_vld", {63'h0, rsp_valid}, 64'h0);
    check("rst_lvl", {60'h0, snap_level}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-level rollback restores the level-0 value.
    issue(WR, 1'b0, 4'd3, 32'h11);
    check("w0_vld", {63'h0, rsp_valid}, 64'h1);
    check("w0_rdata", {32'h0, rsp_rdata}, 64'h0);
    issue(SN, 1'b0, 4'd0, 32'h0);
    check("sn_lvl", {60'h0, snap_level}, 64'h1);
    issue(WR, 1'b0, 4'd3, 32'h22);
    check("w1_jc", {58'h0, jrnl_count}, 64'h1);
    read_chk("rd_a3_22", 1'b0, 4'd3, 32'h22);
    issue(RB, 1'b0, 4'd0, 32'h0);
    check("rb_ready", {63'h0, cmd_ready}, 64'h0);
    wait_done(bcyc);
    check("rb1_cyc", 64'(bcyc), 64'd1);
    check("rb1_vld", {63'h0, rsp_valid}, 64'h1);
    check("rb1_err", {63'h0, rsp_err}, 64'h0);
    read_chk("rd_a3_11", 1'b0, 4'd3, 32'h11);
    check("rb1_jc", {58'h0, jrnl_count}, 64'h0);
    check("rb1_lvl", {60'h0, snap_level}, 64'h0);

    // Committed inner entries are still undone by the parent rollback.
    issue(WR, 1'b0, 4'd1, 32'h77);
    issue(SN, 1'b0, 4'd0, 32'h0);
    issue(WR, 1'b0, 4'd1, 32'h5);
    issue(SN, 1'b0, 4'd0, 32'h0);
    issue(WR, 1'b0, 4'd1, 32'h6);
    issue(CM, 1'b0, 4'd0, 32'h0);
    check("cm_err", {63'h0, rsp_err}, 64'h0);
    check("cm_lvl", {60'h0, snap_level}, 64'h1);
    check("cm_jc", {58'h0, jrnl_count}, 64'h2);
    issue(RB, 1'b0, 4'd0, 32'h0);
    wait_done(bcyc);
    check("rb2_cyc", 64'(bcyc), 64'd2);
    check("rb2_vld", {63'h0, rsp_valid}, 64'h1);
    read_chk("rd_a1_77", 1'b0, 4'd1, 32'h77);
    check("rb2_lvl", {60'h0, snap_level}, 64'h0);

    // Level-0 and undefined commands are rejected without side effects.
    issue(CM, 1'b0, 4'd0, 32'h0);
    check("cm0_err", {63'h0, rsp_err}, 64'h1);
    issue(RB, 1'b0, 4'd0, 32'h0);
    check("rb0_vld", {63'h0, rsp_valid}, 64'h1);
    check("rb0_err", {63'h0, rsp_err}, 64'h1);
    issue(3'd7, 1'b0, 4'd1, 32'h99);
    check("op7_err", {63'h0, rsp_err}, 64'h1);
    check("op7_rdata", {32'h0, rsp_rdata}, 64'h0);
    read_chk("rd_a1_kept", 1'b0, 4'd1, 32'h77);
    check("op7_lvl", {60'h0, snap_level}, 64'h0);

    // Empty rollback completes on the next cycle.
    issue(SN, 1'b0, 4'd0, 32'h0);
    issue(RB, 1'b0, 4'd0, 32'h0);
    check("rbe_vld", {63'h0, rsp_valid}, 64'h1);
    check("rbe_busy", {63'h0, busy}, 64'h0);
    check("rbe_lvl", {60'h0, snap_level}, 64'h0);

    // Transient sweep leaves the persistent bank alone.
    issue(WR, 1'b1, 4'd2, 32'hAB);
    issue(WR, 1'b0, 4'd2, 32'hCD);
    read_chk("rd_t2_ab", 1'b1, 4'd2, 32'hAB);
    issue(ET, 1'b0, 4'd0, 32'h0);
    wait_done(bcyc);
    check("et_cyc", 64'(bcyc), 64'd16);
    check("et_vld", {63'h0, rsp_valid}, 64'h1);
    read_chk("rd_t2_0", 1'b1, 4'd2, 32'h0);
    read_chk("rd_p2_cd", 1'b0, 4'd2, 32'hCD);
    read_chk("rd_p3_11", 1'b0, 4'd3, 32'h11);

    // Journal and snapshot stack limits.
    issue(SN, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      issue(WR, 1'b0, 4'(i % 16), 32'h100 + 32'(i));
    end
    check("jfull_jc", {58'h0, jrnl_count}, 64'd32);
    issue(WR, 1'b0, 4'd5, 32'hDEAD);
    check("jfull_err", {63'h0, rsp_err}, 64'h1);
    check("jfull_jc2", {58'h0, jrnl_count}, 64'd32);
    read_chk("rd_a5_115", 1'b0, 4'd5, 32'h115);
    for (int i = 0; i < 7; i++) begin
      issue(SN, 1'b0, 4'd0, 32'h0);
    end
    check("sfull_lvl", {60'h0, snap_level}, 64'd8);
    issue(SN, 1'b0, 4'd0, 32'h0);
    check("sfull_err", {63'h0, rsp_err}, 64'h1);
    check("sfull_lvl2", {60'h0, snap_level}, 64'd8);
    issue(ET, 1'b0, 4'd0, 32'h0);
    wait_done(bcyc);
    check("et2_lvl", {60'h0, snap_level}, 64'h0);
    check("et2_jc", {58'h0, jrnl_count}, 64'h0);

    // Reset in the third rollback cycle clears everything.
    issue(SN, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      issue(WR, 1'b0, 4'(i), 32'hA0 + 32'(i));
    end
    issue(RB, 1'b0, 4'd0, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_rb_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_ready", {63'h0, cmd_ready}, 64'h1);
    check("post_lvl", {60'h0, snap_level}, 64'h0);
    check("post_jc", {58'h0, jrnl_count}, 64'h0);
    read_chk("rd_post_a0", 1'b0, 4'd0, 32'h0);
    read_chk("rd_post_a3", 1'b0, 4'd3, 32'h0);
    read_chk("rd_post_a5", 1'b0, 4'd5, 32'h0);
    read_chk("rd_post_p2", 1'b0, 4'd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
